// File: rtl/uart_tx_serializer.sv
// UART TX framer: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Latency: the start bit is on tx_out the cycle after accept; one clk cycle per frame bit.
// Backpressure: ready is high only in IDLE or the final stop cycle; data_valid is ignored otherwise.
//
// Ports:
//   clk           bit-rate clock, rising edge
//   rst           asynchronous reset, active-low
//   data_in       payload word, captured on accept
//   data_valid    word offered on data_in
//   parity_enable frame carries a parity bit (captured on accept)
//   parity_bit    parity from the upstream calculator, stable from the cycle after accept
//   data_accept   data_valid & ready; doubles as the parity calculator's data_valid
//   ready         a word can be accepted this cycle
//   tx_out        registered serial line, idle high
//   busy          registered, high while a frame occupies the line
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  parity_enable,
    input  logic                  parity_bit,
    output logic                  data_accept,
    output logic                  ready,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    // The bit counter indexes data bits in DATA and stop bits in STOP;
    // DATA_WIDTH >= 5 guarantees CNT_W >= 3, so it always fits STOP_BITS-1.
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                  state_q;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   shift_nxt;
    logic                    par_en_q;
    logic                    par_en_nxt;
    logic                    tx_q;
    logic                    tx_nxt;
    logic                    busy_q;
    logic                    busy_nxt;
    logic                    last_stop;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Accepting in the final stop cycle lets frames run back-to-back with
    // no idle bit between them.
    assign last_stop   = (state_q == ST_STOP) && (cnt_q == LAST_STOP);
    assign ready       = (state_q == ST_IDLE) || last_stop;
    assign data_accept = data_valid & ready;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // tx_nxt is the line value for the cycle being entered, so tx_out is a
    // plain flop with no combinational path to the pin.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        shift_nxt  = shift_q;
        par_en_nxt = par_en_q;
        tx_nxt     = tx_q;

        unique case (state_q)
            ST_IDLE: begin
                tx_nxt = 1'b1;
            end

            ST_START: begin
                state_nxt = ST_DATA;
                cnt_nxt   = '0;
                tx_nxt    = shift_q[0];
                shift_nxt = shift_q >> 1;
            end

            ST_DATA: begin
                if (cnt_q == LAST_DATA) begin
                    cnt_nxt = '0;
                    if (par_en_q) begin
                        // The calculator only updates on data_accept, which
                        // cannot fire mid-frame, so parity_bit here equals the
                        // value present during the PARITY cycle itself.
                        state_nxt = ST_PARITY;
                        tx_nxt    = parity_bit;
                    end else begin
                        state_nxt = ST_STOP;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    cnt_nxt   = cnt_q + CNT_W'(1);
                    tx_nxt    = shift_q[0];
                    shift_nxt = shift_q >> 1;
                end
            end

            ST_PARITY: begin
                state_nxt = ST_STOP;
                cnt_nxt   = '0;
                tx_nxt    = 1'b1;
            end

            ST_STOP: begin
                tx_nxt = 1'b1;
                if (cnt_q == LAST_STOP) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                tx_nxt    = 1'b1;
            end
        endcase

        // Accept can only happen in IDLE or the final stop cycle; in both
        // cases it overrides the default path and starts a new frame.
        if (data_accept) begin
            state_nxt  = ST_START;
            cnt_nxt    = '0;
            shift_nxt  = data_in;
            par_en_nxt = parity_enable;
            tx_nxt     = 1'b0;
        end
    end

    assign busy_nxt = (state_nxt != ST_IDLE);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Reset drops a frame in flight immediately: the line goes high with no
    // partial stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            shift_q  <= shift_nxt;
            par_en_q <= par_en_nxt;
            tx_q     <= tx_nxt;
            busy_q   <= busy_nxt;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: one instance with 1 stop bit, one with 2.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
// Expected line bits are queued at accept time and popped cycle by cycle.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       parity_enable;
    logic       parity_bit;

    logic       data_accept;
    logic       ready;
    logic       tx_out;
    logic       busy;

    logic       data_accept2;
    logic       ready2;
    logic       tx_out2;
    logic       busy2;

    logic       exp_q[$];
    int         chk_cnt  = 0;
    int         pass_cnt = 0;

    logic [7:0] par_words [2] = '{8'h07, 8'hA5};

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .DATA_WIDTH (8),
        .STOP_BITS  (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .parity_enable (parity_enable),
        .parity_bit    (parity_bit),
        .data_accept   (data_accept),
        .ready         (ready),
        .tx_out        (tx_out),
        .busy          (busy)
    );

    uart_tx_serializer #(
        .DATA_WIDTH (8),
        .STOP_BITS  (2)
    ) dut2 (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .parity_enable (parity_enable),
        .parity_bit    (parity_bit),
        .data_accept   (data_accept2),
        .ready         (ready2),
        .tx_out        (tx_out2),
        .busy          (busy2)
    );

    // Reference frame: start 0, data LSB first, even parity if enabled, stop 1s.
    function automatic void push_frame(input logic [7:0] d, input logic pe, input int stops);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(^d);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endfunction

    task automatic test_reset();
        logic e;
        @(negedge clk); #1;
        chk_cnt++; if (tx_out !== 1'b1) $display("FAIL reset_tx_out: got %b want 1", tx_out); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else pass_cnt++;
        rst = 1'b1;

        // Start 0xA5 and kill it while data bit 1 (a 0) is on the line.
        @(negedge clk);
        data_in = 8'hA5; data_valid = 1'b1; parity_enable = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            data_valid = 1'b0;
        end
        rst = 1'b0; #1;
        chk_cnt++; if (tx_out !== 1'b1) $display("FAIL midframe_rst_tx_out: got %b want 1", tx_out); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL midframe_rst_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (ready !== 1'b1) $display("FAIL midframe_rst_ready: got %b want 1", ready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;

        // A fresh frame after reset must be complete and correct.
        @(negedge clk);
        data_in = 8'h3C; data_valid = 1'b1; #1;
        chk_cnt++; if (data_accept !== 1'b1) $display("FAIL post_rst_accept: got %b want 1", data_accept); else pass_cnt++;
        exp_q.delete();
        push_frame(8'h3C, 1'b0, 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            data_valid = 1'b0; #1;
            e = exp_q.pop_front();
            chk_cnt++; if (tx_out !== e) $display("FAIL post_rst_bit%0d: got %b want %b", k, tx_out, e); else pass_cnt++;
        end
        @(negedge clk); #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL post_rst_busy_end: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_no_parity();
        logic e;
        @(negedge clk);
        data_in = 8'hA5; data_valid = 1'b1; parity_enable = 1'b0; #1;
        chk_cnt++; if (data_accept !== 1'b1) $display("FAIL np_accept: got %b want 1", data_accept); else pass_cnt++;
        exp_q.delete();
        push_frame(8'hA5, 1'b0, 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            data_valid = 1'b0; data_in = 8'hFF; #1;
            e = exp_q.pop_front();
            chk_cnt++; if (tx_out !== e) $display("FAIL np_bit%0d: got %b want %b", k, tx_out, e); else pass_cnt++;
            chk_cnt++; if (busy !== 1'b1) $display("FAIL np_busy%0d: got %b want 1", k, busy); else pass_cnt++;
            chk_cnt++; if (ready !== (k == 10)) $display("FAIL np_ready%0d: got %b want %b", k, ready, (k == 10)); else pass_cnt++;
        end
        @(negedge clk); #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL np_busy_end: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (tx_out !== 1'b1) $display("FAIL np_idle_line: got %b want 1", tx_out); else pass_cnt++;
    endtask

    task automatic test_parity();
        logic       e;
        logic [7:0] d;
        for (int w = 0; w < 2; w++) begin
            d = par_words[w];
            @(negedge clk);
            data_in = d; data_valid = 1'b1; parity_enable = 1'b1;
            parity_bit = ~(^d); // stale value from the previous word
            #1;
            chk_cnt++; if (data_accept !== 1'b1) $display("FAIL par_accept_w%0d: got %b want 1", w, data_accept); else pass_cnt++;
            exp_q.delete();
            push_frame(d, 1'b1, 1);
            for (int k = 1; k <= 11; k++) begin
                @(negedge clk);
                data_valid = 1'b0;
                if (k == 1) begin
                    parity_bit    = ^d;
                    parity_enable = 1'b0; // no effect until the next accept
                end
                #1;
                e = exp_q.pop_front();
                chk_cnt++; if (tx_out !== e) $display("FAIL par_w%0d_bit%0d: got %b want %b", w, k, tx_out, e); else pass_cnt++;
                chk_cnt++; if (busy !== 1'b1) $display("FAIL par_w%0d_busy%0d: got %b want 1", w, k, busy); else pass_cnt++;
            end
            @(negedge clk); #1;
            chk_cnt++; if (busy !== 1'b0) $display("FAIL par_w%0d_busy_end: got %b want 0", w, busy); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        @(negedge clk);
        data_in = 8'h55; data_valid = 1'b1; parity_enable = 1'b0; #1;
        chk_cnt++; if (data_accept !== 1'b1) $display("FAIL b2b_accept0: got %b want 1", data_accept); else pass_cnt++;
        exp_q.delete();
        push_frame(8'h55, 1'b0, 1);
        // Cycle 10 is the first frame's only stop cycle; 0x0F is offered there.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k < 10) begin
                data_in = 8'h55; data_valid = 1'b1;
            end else if (k == 10) begin
                data_in = 8'h0F; data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
            #1;
            if (k <= 10) begin
                chk_cnt++; if (data_accept !== (k == 10)) $display("FAIL b2b_accept_c%0d: got %b want %b", k, data_accept, (k == 10)); else pass_cnt++;
            end
            if (k == 10) push_frame(8'h0F, 1'b0, 1);
            e = exp_q.pop_front();
            chk_cnt++; if (tx_out !== e) $display("FAIL b2b_bit%0d: got %b want %b", k, tx_out, e); else pass_cnt++;
            chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy%0d: got %b want 1", k, busy); else pass_cnt++;
        end
        @(negedge clk); #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_ignored_valid();
        logic e;
        @(negedge clk);
        data_in = 8'h3C; data_valid = 1'b1; parity_enable = 1'b1; parity_bit = 1'b1; #1;
        chk_cnt++; if (data_accept !== 1'b1) $display("FAIL ign_accept: got %b want 1", data_accept); else pass_cnt++;
        exp_q.delete();
        push_frame(8'h3C, 1'b1, 1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) parity_bit = 1'b0; // even parity of 0x3C
            if (k >= 3 && k <= 6) begin
                data_in = 8'hFF; data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
            #1;
            if (k >= 3 && k <= 6) begin
                chk_cnt++; if (data_accept !== 1'b0) $display("FAIL ign_accept_c%0d: got %b want 0", k, data_accept); else pass_cnt++;
            end
            e = exp_q.pop_front();
            chk_cnt++; if (tx_out !== e) $display("FAIL ign_bit%0d: got %b want %b", k, tx_out, e); else pass_cnt++;
        end
        @(negedge clk); #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL ign_busy_end: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_two_stop();
        logic e;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        data_in = 8'h07; data_valid = 1'b1; parity_enable = 1'b1; parity_bit = 1'b0; #1;
        chk_cnt++; if (data_accept2 !== 1'b1) $display("FAIL two_stop_accept: got %b want 1", data_accept2); else pass_cnt++;
        exp_q.delete();
        push_frame(8'h07, 1'b1, 2);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            data_valid = 1'b0;
            if (k == 1) parity_bit = 1'b1; // even parity of 0x07
            #1;
            e = exp_q.pop_front();
            chk_cnt++; if (tx_out2 !== e) $display("FAIL two_stop_bit%0d: got %b want %b", k, tx_out2, e); else pass_cnt++;
            chk_cnt++; if (busy2 !== 1'b1) $display("FAIL two_stop_busy%0d: got %b want 1", k, busy2); else pass_cnt++;
            chk_cnt++; if (ready2 !== (k == 12)) $display("FAIL two_stop_ready%0d: got %b want %b", k, ready2, (k == 12)); else pass_cnt++;
        end
        @(negedge clk); #1;
        chk_cnt++; if (busy2 !== 1'b0) $display("FAIL two_stop_busy_end: got %b want 0", busy2); else pass_cnt++;
        chk_cnt++; if (tx_out2 !== 1'b1) $display("FAIL two_stop_idle_line: got %b want 1", tx_out2); else pass_cnt++;
    endtask

    initial begin
        rst           = 1'b0;
        data_in       = 8'h00;
        data_valid    = 1'b0;
        parity_enable = 1'b0;
        parity_bit    = 1'b0;

        test_reset();
        test_no_parity();
        test_parity();
        test_back_to_back();
        test_ignored_valid();
        test_two_stop();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
